// File: rtl/vc_to_d_arbiter_if.sv
// Handshake bundle between the arbiter, the two VC FIFOs and the two
// destination FIFOs. The arbiter side uses the master modport.
interface vc_to_d_arbiter_if #(
  parameter int unsigned data_width = 6
);
  logic                  vc0_empty;
  logic                  vc1_empty;
  logic [data_width-1:0] vc0_data;
  logic [data_width-1:0] vc1_data;
  logic                  vc0_pop;
  logic                  vc1_pop;
  logic                  d0_almost_full;
  logic                  d1_almost_full;
  logic                  d0_push;
  logic                  d1_push;
  logic [data_width-1:0] d_data;

  modport master (
    input  vc0_empty, vc1_empty, vc0_data, vc1_data,
    input  d0_almost_full, d1_almost_full,
    output vc0_pop, vc1_pop, d0_push, d1_push, d_data
  );

  modport slave (
    output vc0_empty, vc1_empty, vc0_data, vc1_data,
    output d0_almost_full, d1_almost_full,
    input  vc0_pop, vc1_pop, d0_push, d1_push, d_data
  );
endinterface

// File: rtl/vc_to_d_arbiter.sv
// VC0/VC1 to D0/D1 arbiter: VC0 priority with a programmable anti-starvation
// counter for VC1, destination routing from a word bit, pause-aware eligibility.
module vc_to_d_arbiter #(
  parameter int unsigned data_width = 6,
  parameter int unsigned DEST_BIT   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [3:0]           vc1_burst_max,
  vc_to_d_arbiter_if.master    bus,
  output logic [7:0]           grant_cnt_vc0,
  output logic [7:0]           grant_cnt_vc1,
  output logic                 idle
);

  logic                  dest0, dest1;
  logic                  el0, el1;
  logic                  grant0, grant1;
  logic                  d0_push_q, d0_push_d;
  logic                  d1_push_q, d1_push_d;
  logic [data_width-1:0] d_data_q, d_data_d;
  logic [3:0]            starve_cnt_q, starve_cnt_d;
  logic [7:0]            grant_cnt_vc0_q, grant_cnt_vc0_d;
  logic [7:0]            grant_cnt_vc1_q, grant_cnt_vc1_d;

  // Eligibility and grant selection; a head is blocked only by its own destination's pause.
  always_comb begin
    dest0  = bus.vc0_data[DEST_BIT];
    dest1  = bus.vc1_data[DEST_BIT];
    el0    = reset & enable & ~bus.vc0_empty &
             ~(dest0 ? bus.d1_almost_full : bus.d0_almost_full);
    el1    = reset & enable & ~bus.vc1_empty &
             ~(dest1 ? bus.d1_almost_full : bus.d0_almost_full);
    grant1 = el1 & (~el0 | ((vc1_burst_max != 4'd0) && (starve_cnt_q >= vc1_burst_max)));
    grant0 = el0 & ~grant1;
  end

  // Next-state for push register, starvation counter and grant counters.
  always_comb begin
    d_data_d        = d_data_q;
    d0_push_d       = 1'b0;
    d1_push_d       = 1'b0;
    starve_cnt_d    = starve_cnt_q;
    grant_cnt_vc0_d = grant_cnt_vc0_q;
    grant_cnt_vc1_d = grant_cnt_vc1_q;
    if (grant0) begin
      d_data_d        = bus.vc0_data;
      d0_push_d       = ~dest0;
      d1_push_d       = dest0;
      grant_cnt_vc0_d = grant_cnt_vc0_q + 8'd1;
    end else if (grant1) begin
      d_data_d        = bus.vc1_data;
      d0_push_d       = ~dest1;
      d1_push_d       = dest1;
      grant_cnt_vc1_d = grant_cnt_vc1_q + 8'd1;
    end
    if (bus.vc1_empty || grant1) begin
      starve_cnt_d = '0;
    end else if (grant0 && el1 && (starve_cnt_q != 4'd15)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_data_q        <= '0;
      d0_push_q       <= 1'b0;
      d1_push_q       <= 1'b0;
      starve_cnt_q    <= '0;
      grant_cnt_vc0_q <= '0;
      grant_cnt_vc1_q <= '0;
    end else begin
      d_data_q        <= d_data_d;
      d0_push_q       <= d0_push_d;
      d1_push_q       <= d1_push_d;
      starve_cnt_q    <= starve_cnt_d;
      grant_cnt_vc0_q <= grant_cnt_vc0_d;
      grant_cnt_vc1_q <= grant_cnt_vc1_d;
    end
  end

  // Output drive; idle is forced high while reset is held.
  always_comb begin
    bus.vc0_pop   = grant0;
    bus.vc1_pop   = grant1;
    bus.d0_push   = d0_push_q;
    bus.d1_push   = d1_push_q;
    bus.d_data    = d_data_q;
    grant_cnt_vc0 = grant_cnt_vc0_q;
    grant_cnt_vc1 = grant_cnt_vc1_q;
    idle          = ~reset | (bus.vc0_empty & bus.vc1_empty & ~d0_push_q & ~d1_push_q);
  end

endmodule

// File: tb/tb_vc_to_d_arbiter.sv
// Self-checking bench for vc_to_d_arbiter: queue-based FIFO/arbitration model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_vc_to_d_arbiter;
  localparam int DW = 6;
  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] burst;
  logic [7:0] grant_cnt_vc0, grant_cnt_vc1;
  logic       idle;

  vc_to_d_arbiter_if #(.data_width(DW)) bus ();

  vc_to_d_arbiter #(.data_width(DW), .DEST_BIT(DB)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .vc1_burst_max (burst),
    .bus           (bus),
    .grant_cnt_vc0 (grant_cnt_vc0),
    .grant_cnt_vc1 (grant_cnt_vc1),
    .idle          (idle)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // FIFO contents as seen by the arbiter, plus model state
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  int            glog[$];
  int            e_cnt0, e_cnt1, starve;
  logic          e_p0, e_p1;
  logic [DW-1:0] e_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit paused(input logic d);
    return d ? bus.d1_almost_full : bus.d0_almost_full;
  endfunction

  function automatic bit model_el(input int c);
    logic [DW-1:0] w;
    if (!reset || !enable) return 1'b0;
    if (c == 0) begin
      if (q0.size() == 0) return 1'b0;
      w = q0[0];
    end else begin
      if (q1.size() == 0) return 1'b0;
      w = q1[0];
    end
    return !paused(w[DB]);
  endfunction

  // -1 none, 0 VC0, 1 VC1
  function automatic int model_grant();
    bit a, b;
    a = model_el(0);
    b = model_el(1);
    if (a && b) return (burst != 0 && starve >= int'(burst)) ? 1 : 0;
    if (a) return 0;
    if (b) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    e_cnt0 = 0; e_cnt1 = 0; starve = 0;
    e_p0 = 1'b0; e_p1 = 1'b0; e_data = '0;
  endtask

  task automatic model_update(input int g);
    bit            v1e, b;
    logic [DW-1:0] w;
    if (!reset) begin
      model_reset();
      return;
    end
    v1e  = (q1.size() == 0);
    b    = model_el(1);
    e_p0 = 1'b0;
    e_p1 = 1'b0;
    if (g == 0) begin
      w = q0.pop_front();
      e_cnt0 = (e_cnt0 + 1) % 256;
    end else if (g == 1) begin
      w = q1.pop_front();
      e_cnt1 = (e_cnt1 + 1) % 256;
    end
    if (g >= 0) begin
      e_data = w;
      if (w[DB]) e_p1 = 1'b1; else e_p0 = 1'b1;
    end
    if (v1e || g == 1) starve = 0;
    else if (g == 0 && b && starve < 15) starve++;
  endtask

  task automatic drive_vc();
    bus.vc0_empty = (q0.size() == 0);
    bus.vc1_empty = (q1.size() == 0);
    bus.vc0_data  = (q0.size() != 0) ? q0[0] : DW'($urandom);
    bus.vc1_data  = (q1.size() != 0) ? q1[0] : DW'($urandom);
  endtask

  // One clock: compare everything at negedge+1, then advance the model at the edge.
  task automatic cycle();
    int   g;
    logic exp_idle;
    @(negedge clk);
    drive_vc();
    #1;
    g = model_grant();
    exp_idle = !reset || (q0.size() == 0 && q1.size() == 0 && !e_p0 && !e_p1);
    chk("vc0_pop",  bus.vc0_pop, (g == 0));
    chk("vc1_pop",  bus.vc1_pop, (g == 1));
    chk("d0_push",  bus.d0_push, e_p0);
    chk("d1_push",  bus.d1_push, e_p1);
    chk("d_data",   bus.d_data, e_data);
    chk("cnt_vc0",  grant_cnt_vc0, e_cnt0);
    chk("cnt_vc1",  grant_cnt_vc1, e_cnt1);
    chk("idle",     idle, exp_idle);
    glog.push_back(bus.vc1_pop ? 1 : (bus.vc0_pop ? 0 : -1));
    @(posedge clk);
    model_update(g);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    q0.delete();
    q1.delete();
    drive_vc();
    @(posedge clk);
    #1;
    reset = 1'b1;
    glog.delete();
  endtask

  task automatic chk_log(input string name, input int exp[]);
    for (int i = 0; i < exp.size(); i++) begin
      if (i < glog.size()) chk(name, glog[i], exp[i]);
      else chk(name, 32'hFFFF_FFFF, exp[i]);
    end
  endtask

  initial begin
    reset = 1'b0;
    enable = 1'b1;
    burst = 4'd0;
    bus.d0_almost_full = 1'b0;
    bus.d1_almost_full = 1'b0;
    model_reset();
    q0.push_back(6'b000001);
    drive_vc();
    #1;
    // reset state: pops forced low even with data present
    chk("rst_vc0_pop", bus.vc0_pop, 0);
    chk("rst_d0_push", bus.d0_push, 0);
    chk("rst_d_data",  bus.d_data, 0);
    chk("rst_cnt0",    grant_cnt_vc0, 0);
    chk("rst_idle",    idle, 1);

    // strict priority
    do_reset();
    burst = 4'd0;
    for (int i = 0; i < 3; i++) begin
      q0.push_back(DW'($urandom) & 6'b101111);
      q1.push_back(DW'($urandom) & 6'b101111);
    end
    for (int i = 0; i < 8; i++) cycle();
    chk_log("strict_seq", '{0, 0, 0, 1, 1, 1, -1, -1});
    chk("strict_cnt0", grant_cnt_vc0, 3);
    chk("strict_cnt1", grant_cnt_vc1, 3);

    // anti-starvation
    do_reset();
    burst = 4'd2;
    for (int i = 0; i < 12; i++) begin
      while (q0.size() < 2) q0.push_back(DW'($urandom));
      while (q1.size() < 2) q1.push_back(DW'($urandom));
      cycle();
    end
    chk_log("burst_seq", '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1});
    chk("burst_cnt0", grant_cnt_vc0, 8);
    chk("burst_cnt1", grant_cnt_vc1, 4);

    // routing and pause
    do_reset();
    burst = 4'd0;
    q0.push_back(6'b010110);
    q1.push_back(6'b000101);
    bus.d1_almost_full = 1'b1;
    cycle();
    chk("route_d0_push", bus.d0_push, 1);
    chk("route_d_data1", bus.d_data, 6'b000101);
    bus.d1_almost_full = 1'b0;
    cycle();
    chk("route_d1_push", bus.d1_push, 1);
    chk("route_d_data0", bus.d_data, 6'b010110);
    chk_log("route_seq", '{1, 0});

    // enable drop mid-stream
    do_reset();
    for (int i = 0; i < 3; i++) q0.push_back(DW'($urandom));
    cycle();
    enable = 1'b0;
    chk("endrop_push", bus.d0_push | bus.d1_push, 1);
    for (int i = 0; i < 3; i++) cycle();
    chk_log("endrop_seq", '{0, -1, -1, -1});
    chk("endrop_idle", idle, 0);
    enable = 1'b1;

    // asynchronous reset during an in-flight push
    do_reset();
    for (int i = 0; i < 3; i++) q0.push_back(DW'($urandom) & 6'b101111);
    cycle();
    chk("arst_inflight", bus.d0_push, 1);
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    chk("arst_d0_push", bus.d0_push, 0);
    chk("arst_d_data",  bus.d_data, 0);
    chk("arst_cnt0",    grant_cnt_vc0, 0);
    chk("arst_idle",    idle, 1);
    chk("arst_pop",     bus.vc0_pop, 0);
    reset = 1'b1;
    glog.delete();
    cycle();
    chk_log("arst_first", '{0});

    // grant counter wrap
    do_reset();
    for (int i = 0; i < 256; i++) begin
      if (q0.size() == 0) q0.push_back(DW'($urandom));
      cycle();
      if (i == 254) chk("wrap_255", grant_cnt_vc0, 255);
    end
    chk("wrap_0", grant_cnt_vc0, 0);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0 && q0.size() < 8) q0.push_back(DW'($urandom));
      if ($urandom_range(0, 2) == 0 && q1.size() < 8) q1.push_back(DW'($urandom));
      enable = ($urandom_range(0, 7) != 0);
      bus.d0_almost_full = ($urandom_range(0, 3) == 0);
      bus.d1_almost_full = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 49) == 0) burst = 4'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #1;
        reset = 1'b0;
        model_reset();
        cycle();
        reset = 1'b1;
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
